// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding and TX mux select codes,
// used by the TX FSM, the TX output mux and the RX path.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   localparam logic [1:0] MUX_START = 2'b00;
   localparam logic [1:0] MUX_DATA  = 2'b01;
   localparam logic [1:0] MUX_PAR   = 2'b10;
   localparam logic [1:0] MUX_STOP  = 2'b11;

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Payload handshake and mux-control bundle between the byte source, the TX FSM and the TX mux.
interface uart_tx_fsm_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [1:0]            mux_sel;
   logic                  ser_data;
   logic                  par_bit;
   logic                  busy;

   modport master (
      output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
      input  mux_sel, ser_data, par_bit, busy
   );

   modport slave (
      input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
      output mux_sel, ser_data, par_bit, busy
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// LSB-first shift register plus a shared phase counter; done_o flags the last
// cycle of the counted phase (DATA_WIDTH data bits, or STOP_LAST+1 stop cycles).
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_LAST  = 0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  shift_en_i,
   input  logic                  cnt_en_i,
   input  logic                  stop_i,
   output logic                  ser_o,
   output logic                  done_o
);
   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] STOP_LST  = CW'(STOP_LAST);

   logic [DATA_WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   assign ser_o  = sr_q[0];
   assign done_o = (cnt_q == (stop_i ? STOP_LST : DATA_LAST));

   // Counter wraps to zero on done so the next phase starts from a clean count.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (load_i) begin
         sr_d  = data_i;
         cnt_d = '0;
      end else begin
         if (shift_en_i)
            sr_d = {1'b0, sr_q[DATA_WIDTH-1:1]};
         if (shift_en_i || cnt_en_i)
            cnt_d = done_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/uart_tx_fsm.sv
// UART TX frame sequencer: start, DATA_WIDTH data bits LSB-first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to emit two stop cycles instead of one.
module uart_tx_fsm
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic           CLK,
   input  logic           RST,
   uart_tx_fsm_if.slave   tx
);
`ifdef UART_TX_TWO_STOP_EN
   localparam int STOP_LAST = 1;
`else
   localparam int STOP_LAST = 0;
`endif

   tx_state_e state_q, state_d;
   logic      par_q, par_d;
   logic      par_en_q, par_en_d;
   logic      load, shift_en, cnt_en, ser_done;

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH),
      .STOP_LAST  (STOP_LAST)
   ) u_ser (
      .CLK        (CLK),
      .RST        (RST),
      .load_i     (load),
      .data_i     (tx.P_DATA),
      .shift_en_i (shift_en),
      .cnt_en_i   (cnt_en),
      .stop_i     (state_q == ST_STOP),
      .ser_o      (tx.ser_data),
      .done_o     (ser_done)
   );

   always_comb begin
      state_d  = state_q;
      par_d    = par_q;
      par_en_d = par_en_q;
      load     = 1'b0;
      shift_en = 1'b0;
      cnt_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tx.Data_Valid) begin
               load     = 1'b1;
               par_d    = (^tx.P_DATA) ^ tx.PAR_TYP;
               par_en_d = tx.PAR_EN;
               state_d  = ST_START;
            end
         end
         ST_START:  state_d = ST_DATA;
         ST_DATA: begin
            shift_en = 1'b1;
            if (ser_done)
               state_d = par_en_q ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: state_d = ST_STOP;
         ST_STOP: begin
            cnt_en = 1'b1;
            if (ser_done)
               state_d = ST_IDLE;
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= ST_IDLE;
         par_q    <= 1'b0;
         par_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         par_q    <= par_d;
         par_en_q <= par_en_d;
      end
   end

   // Moore decode: select and busy depend on registered state only.
   always_comb begin
      case (state_q)
         ST_START:  tx.mux_sel = MUX_START;
         ST_DATA:   tx.mux_sel = MUX_DATA;
         ST_PARITY: tx.mux_sel = MUX_PAR;
         default:   tx.mux_sel = MUX_STOP;
      endcase
   end

   assign tx.busy    = (state_q != ST_IDLE);
   assign tx.par_bit = par_q;
endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm: table of frames with hand-computed parity and length,
// plus reset, ignore-while-busy, back-to-back and mid-frame abort sequences.
module tb_uart_tx_fsm;
   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   n_total = 0;
   int   n_pass  = 0;

   uart_tx_fsm_if #(.DATA_WIDTH(8)) tx_if ();

   uart_tx_fsm #(.DATA_WIDTH(8)) dut (
      .CLK (CLK),
      .RST (RST),
      .tx  (tx_if.slave)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] data;
      logic       en;
      logic       typ;
      logic       exp_par;
      int         len;   // busy cycles with a single stop bit
      int         mode;  // 0 plain, 1 pulse 0xFF mid-DATA, 2 hold valid, 3 reset in 4th DATA cycle
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] d;
      int         len;
      int         exp_mux;
      d   = v.data;
      len = v.len;
`ifdef UART_TX_TWO_STOP_EN
      len = len + 1;
`endif
      tx_if.P_DATA     = v.data;
      tx_if.PAR_EN     = v.en;
      tx_if.PAR_TYP    = v.typ;
      tx_if.Data_Valid = 1'b1;
      tick();
      if (v.mode != 2) tx_if.Data_Valid = 1'b0;
      for (int k = 0; k < len; k++) begin
         if (k > 0) tick();
         if (k == 0)                exp_mux = 0;
         else if (k <= 8)           exp_mux = 1;
         else if (v.en && k == 9)   exp_mux = 2;
         else                       exp_mux = 3;
         chk($sformatf("mux_sel k=%0d", k), int'(tx_if.mux_sel), exp_mux);
         chk($sformatf("busy k=%0d", k), int'(tx_if.busy), 1);
         if (exp_mux == 1)
            chk($sformatf("ser_data bit%0d", k - 1), int'(tx_if.ser_data), int'(d[k-1]));
         if (k == 0)
            chk("par_bit at start", int'(tx_if.par_bit), int'(v.exp_par));
         if (v.mode == 1 && k == 3) begin
            tx_if.P_DATA     = 8'hFF;
            tx_if.PAR_EN     = ~v.en;
            tx_if.Data_Valid = 1'b1;
         end
         if (v.mode == 1 && k == 4) tx_if.Data_Valid = 1'b0;
         if (v.mode == 3 && k == 4) begin
            RST = 1'b0;
            #1;
            chk("abort mux_sel", int'(tx_if.mux_sel), 3);
            chk("abort busy", int'(tx_if.busy), 0);
            chk("abort par_bit", int'(tx_if.par_bit), 0);
            tick();
            RST = 1'b1;
            tick();
            chk("post-abort busy", int'(tx_if.busy), 0);
            return;
         end
      end
      tick();
      chk("idle mux_sel", int'(tx_if.mux_sel), 3);
      chk("idle busy", int'(tx_if.busy), 0);
      chk("par_bit held", int'(tx_if.par_bit), int'(v.exp_par));
      if (v.mode == 1) begin
         for (int j = 0; j < 3; j++) begin
            tick();
            chk("no queued frame busy", int'(tx_if.busy), 0);
         end
      end
      if (v.mode == 2) begin
         tick();
         chk("b2b start mux_sel", int'(tx_if.mux_sel), 0);
         chk("b2b start busy", int'(tx_if.busy), 1);
         tx_if.Data_Valid = 1'b0;
         for (int j = 0; j < len; j++) tick();
         chk("b2b end busy", int'(tx_if.busy), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation ran past its time limit");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{data: 8'hA5, en: 1'b1, typ: 1'b0, exp_par: 1'b0, len: 11, mode: 0};
      vecs[1] = '{data: 8'hA5, en: 1'b1, typ: 1'b1, exp_par: 1'b1, len: 11, mode: 0};
      vecs[2] = '{data: 8'h3C, en: 1'b0, typ: 1'b0, exp_par: 1'b0, len: 10, mode: 0};
      vecs[3] = '{data: 8'h7F, en: 1'b1, typ: 1'b1, exp_par: 1'b0, len: 11, mode: 1};
      vecs[4] = '{data: 8'h80, en: 1'b0, typ: 1'b1, exp_par: 1'b0, len: 10, mode: 2};
      vecs[5] = '{data: 8'hA5, en: 1'b1, typ: 1'b0, exp_par: 1'b0, len: 11, mode: 3};
      vecs[6] = '{data: 8'h01, en: 1'b1, typ: 1'b0, exp_par: 1'b1, len: 11, mode: 0};
      vecs[7] = '{data: 8'h00, en: 1'b1, typ: 1'b0, exp_par: 1'b0, len: 11, mode: 0};

      tx_if.P_DATA     = 8'hA5;
      tx_if.PAR_EN     = 1'b1;
      tx_if.PAR_TYP    = 1'b1;
      tx_if.Data_Valid = 1'b1;
      RST              = 1'b0;
      tick();
      tick();
      chk("reset mux_sel", int'(tx_if.mux_sel), 3);
      chk("reset busy", int'(tx_if.busy), 0);
      chk("reset par_bit", int'(tx_if.par_bit), 0);
      chk("reset ser_data", int'(tx_if.ser_data), 0);
      tx_if.Data_Valid = 1'b0;
      RST = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("post-reset idle busy", int'(tx_if.busy), 0);
      end

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i]);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
